i281_prog_loader: RTL and testbench

- Host-side writer for the multicycle i281 CPU.
- Accepts a byte stream over a valid/ready handshake and decodes load commands.
- Writes 16-bit instruction words into code memory and 8-bit bytes into data memory.
- Owns the CPU `run` line: holds the CPU halted during loads and releases it on command.

---
 rtl/i281_loader_pkg.sv | 23 ++
 rtl/i281_loader_addr_ctr.sv | 43 ++++
 rtl/i281_prog_loader.sv | 160 ++++++++++++++++
 tb/tb_i281_prog_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i281_loader_pkg.sv
// Shared definitions for the i281 program loader: command opcodes and the
// loader state encoding.
package i281_loader_pkg;

   localparam logic [1:0] OP_LOAD_CODE = 2'b00;
   localparam logic [1:0] OP_LOAD_DATA = 2'b01;
   localparam logic [1:0] OP_RUN       = 2'b10;
   localparam logic [1:0] OP_HALT      = 2'b11;

   localparam int CNT_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      LEN_C,
      LEN_D,
      CODE_HI,
      CODE_LO,
      WR_C,
      DATA_B,
      WR_D
   } state_e;

endpackage

// File: rtl/i281_loader_addr_ctr.sv
// Loadable wrap-around write address plus remaining-item counter, shared by the
// code and data load paths.
module i281_loader_addr_ctr
   import i281_loader_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_addr_i,
   input  logic [AW-1:0]    addr_i,
   input  logic             load_cnt_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             step_i,
   output logic [AW-1:0]    addr_o,
   output logic             last_o
);

   logic [AW-1:0]    addr_q;
   logic [CNT_W-1:0] cnt_q;

   // Each completed write advances the address (natural wrap) and consumes one item.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (load_addr_i)
            addr_q <= addr_i;
         else if (step_i)
            addr_q <= addr_q + AW'(1);

         if (load_cnt_i)
            cnt_q <= cnt_i;
         else if (step_i)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign addr_o = addr_q;
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/i281_prog_loader.sv
// Byte-stream loader for the i281 CPU: decodes host commands, writes code and
// data memories, and owns the CPU run line.
module i281_prog_loader
   import i281_loader_pkg::*;
#(
   parameter int CODE_AW = 6,
   parameter int DATA_AW = 4,
   parameter int IW      = 16,
   parameter int DW      = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [DW-1:0]      in_data,
   output logic               in_ready,
   output logic               code_we,
   output logic [CODE_AW-1:0] code_addr,
   output logic [IW-1:0]      code_wdata,
   output logic               data_we,
   output logic [DATA_AW-1:0] data_addr,
   output logic [DW-1:0]      data_wdata,
   output logic               cpu_run,
   output logic               busy,
   output logic               err
);

   state_e               state_q;
   logic                 cpu_run_q;
   logic                 err_q;
   logic                 code_we_q;
   logic                 data_we_q;
   logic [CODE_AW-1:0]   code_addr_q;
   logic [DATA_AW-1:0]   data_addr_q;
   logic [IW-1:0]        hold_q;

   logic                 accept;
   logic [1:0]           op;
   logic                 ctr_load_addr;
   logic [CODE_AW-1:0]   ctr_start;
   logic                 ctr_load_cnt;
   logic [CNT_W-1:0]     ctr_cnt;
   logic                 ctr_step;
   logic [CODE_AW-1:0]   ctr_addr;
   logic                 ctr_last;

   assign in_ready = (state_q != WR_C) && (state_q != WR_D);
   assign accept   = in_valid && in_ready;
   assign op       = in_data[7:6];
   assign ctr_cnt  = {1'b0, in_data} + CNT_W'(1);

   // Counter control: start address comes with the command byte, item count with the length byte.
   always_comb begin
      ctr_load_addr = 1'b0;
      ctr_start     = '0;
      ctr_load_cnt  = 1'b0;
      ctr_step      = (state_q == WR_C) || (state_q == WR_D);
      if (accept && state_q == IDLE) begin
         if (op == OP_LOAD_CODE) begin
            ctr_load_addr = 1'b1;
            ctr_start     = in_data[CODE_AW-1:0];
         end else if (op == OP_LOAD_DATA && in_data[5:4] == 2'b00) begin
            ctr_load_addr = 1'b1;
            ctr_start     = CODE_AW'(in_data[DATA_AW-1:0]);
         end
      end
      if (accept && (state_q == LEN_C || state_q == LEN_D))
         ctr_load_cnt = 1'b1;
   end

   i281_loader_addr_ctr #(.AW(CODE_AW)) u_addr_ctr (
      .clock       (clock),
      .reset       (reset),
      .load_addr_i (ctr_load_addr),
      .addr_i      (ctr_start),
      .load_cnt_i  (ctr_load_cnt),
      .cnt_i       (ctr_cnt),
      .step_i      (ctr_step),
      .addr_o      (ctr_addr),
      .last_o      (ctr_last)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cpu_run_q   <= 1'b0;
         err_q       <= 1'b0;
         code_we_q   <= 1'b0;
         data_we_q   <= 1'b0;
         code_addr_q <= '0;
         data_addr_q <= '0;
         hold_q      <= '0;
      end else begin
         code_we_q <= 1'b0;
         data_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  case (op)
                     OP_LOAD_CODE: begin
                        cpu_run_q <= 1'b0;
                        state_q   <= LEN_C;
                     end
                     OP_LOAD_DATA: begin
                        if (in_data[5:4] == 2'b00) begin
                           cpu_run_q <= 1'b0;
                           state_q   <= LEN_D;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                     OP_RUN: cpu_run_q <= 1'b1;
                     default: begin
                        cpu_run_q <= 1'b0;
                        err_q     <= 1'b0;
                     end
                  endcase
               end
            end
            LEN_C:   if (accept) state_q <= CODE_HI;
            LEN_D:   if (accept) state_q <= DATA_B;
            CODE_HI: begin
               if (accept) begin
                  hold_q[IW-1:DW] <= in_data;
                  state_q         <= CODE_LO;
               end
            end
            CODE_LO: begin
               if (accept) begin
                  hold_q[DW-1:0] <= in_data;
                  code_we_q      <= 1'b1;
                  code_addr_q    <= ctr_addr;
                  state_q        <= WR_C;
               end
            end
            WR_C:    state_q <= ctr_last ? IDLE : CODE_HI;
            DATA_B: begin
               if (accept) begin
                  hold_q[DW-1:0] <= in_data;
                  data_we_q      <= 1'b1;
                  data_addr_q    <= ctr_addr[DATA_AW-1:0];
                  state_q        <= WR_D;
               end
            end
            WR_D:    state_q <= ctr_last ? IDLE : DATA_B;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign code_we    = code_we_q;
   assign code_addr  = code_addr_q;
   assign code_wdata = hold_q;
   assign data_we    = data_we_q;
   assign data_addr  = data_addr_q;
   assign data_wdata = hold_q[DW-1:0];
   assign cpu_run    = cpu_run_q;
   assign busy       = (state_q != IDLE);
   assign err        = err_q;

endmodule

// File: tb/tb_i281_prog_loader.sv
// Scoreboard bench for the i281 program loader: directed command streams push
// expected memory writes, and a monitor checks every write strobe against them.
module tb_i281_prog_loader;

   typedef struct packed {
      logic        isCode;
      logic [5:0]  addr;
      logic [15:0] data;
   } wrEntry;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        inValid = 1'b0;
   logic [7:0]  inData = 8'h00;
   logic        inReady;
   logic        codeWe;
   logic [5:0]  codeAddr;
   logic [15:0] codeWdata;
   logic        dataWe;
   logic [3:0]  dataAddr;
   logic [7:0]  dataWdata;
   logic        cpuRun;
   logic        busy;
   logic        err;

   wrEntry expQ[$];
   int     checks = 0;
   int     errors = 0;
   int     codeWrites = 0;
   int     dataWrites = 0;
   int     readyLowCount = 0;

   i281_prog_loader dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (inValid),
      .in_data    (inData),
      .in_ready   (inReady),
      .code_we    (codeWe),
      .code_addr  (codeAddr),
      .code_wdata (codeWdata),
      .data_we    (dataWe),
      .data_addr  (dataAddr),
      .data_wdata (dataWdata),
      .cpu_run    (cpuRun),
      .busy       (busy),
      .err        (err)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic expectWrite(input logic isCode, input logic [5:0] addr, input logic [15:0] data);
      wrEntry e;
      e.isCode = isCode;
      e.addr   = addr;
      e.data   = data;
      expQ.push_back(e);
   endtask

   // Offer one byte after an optional idle gap; returns just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      logic accepted;
      accepted = 1'b0;
      inValid  = 1'b0;
      repeat (gap) @(posedge clock);
      if (gap > 0) #1;
      inValid = 1'b1;
      inData  = b;
      for (int t = 0; t < 40 && !accepted; t++) begin
         @(negedge clock);
         accepted = inReady;
         @(posedge clock);
         #1;
      end
      inValid = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake_timeout byte=%0h", b);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clock) begin
      wrEntry e;
      if (!inReady) readyLowCount++;
      if (reset && (codeWe || dataWe)) begin
         if (codeWe) codeWrites++;
         if (dataWe) dataWrites++;
         checkOutput("single_strobe", 32'(codeWe && dataWe), 32'd0);
         checkOutput("halted_on_write", 32'(cpuRun), 32'd0);
         checkOutput("ready_low_on_write", 32'(inReady), 32'd0);
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write code=%0b addr=%0h", codeWe, codeWe ? 32'(codeAddr) : 32'(dataAddr));
         end else begin
            e = expQ.pop_front();
            checkOutput("write_kind", 32'(codeWe), 32'(e.isCode));
            checkOutput("write_addr", codeWe ? 32'(codeAddr) : 32'(dataAddr), 32'(e.addr));
            checkOutput("write_data", codeWe ? 32'(codeWdata) : 32'(dataWdata), 32'(e.data));
         end
      end
   end

   initial begin
      int cw;
      int dw;

      // Reset state, checked while reset is held and after release.
      #2;
      checkOutput("rst_cpu_run", 32'(cpuRun), 32'd0);
      checkOutput("rst_we", 32'({codeWe, dataWe}), 32'd0);
      idleCycles(2);
      reset = 1'b1;
      idleCycles(1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_ready", 32'(inReady), 32'd1);
      checkOutput("rst_addrs", 32'({codeAddr, dataAddr}), 32'd0);

      // Code load wrapping from 63 to 0.
      expectWrite(1'b1, 6'd62, 16'h1234);
      expectWrite(1'b1, 6'd63, 16'hABCD);
      applyStimulus(8'h3E, 0);
      checkOutput("load_busy", 32'(busy), 32'd1);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      applyStimulus(8'hAB, 0);
      applyStimulus(8'hCD, 0);
      idleCycles(3);
      checkOutput("wrap_writes", 32'(codeWrites), 32'd2);
      checkOutput("wrap_busy", 32'(busy), 32'd0);
      checkOutput("wrap_cpu_run", 32'(cpuRun), 32'd0);
      checkOutput("wrap_addr_hold", 32'(codeAddr), 32'd63);

      // Data load with host stalls.
      expectWrite(1'b0, 6'd15, 16'h0011);
      expectWrite(1'b0, 6'd0, 16'h0022);
      expectWrite(1'b0, 6'd1, 16'h0033);
      applyStimulus(8'h4F, $urandom_range(0, 3));
      applyStimulus(8'h02, $urandom_range(1, 4));
      applyStimulus(8'h11, $urandom_range(0, 4));
      applyStimulus(8'h22, $urandom_range(1, 4));
      applyStimulus(8'h33, $urandom_range(0, 4));
      idleCycles(3);
      checkOutput("stall_data_writes", 32'(dataWrites), 32'd3);
      checkOutput("stall_no_code", 32'(codeWrites), 32'd2);
      checkOutput("stall_busy", 32'(busy), 32'd0);

      // RUN, then a load must halt the CPU on its command edge.
      applyStimulus(8'h80, 0);
      checkOutput("run_set", 32'(cpuRun), 32'd1);
      cw = codeWrites;
      expectWrite(1'b1, 6'd5, 16'hDEAD);
      applyStimulus(8'h05, 0);
      checkOutput("halt_on_load", 32'(cpuRun), 32'd0);
      checkOutput("halt_before_strobe", 32'(codeWrites), 32'(cw));
      applyStimulus(8'h00, 0);
      applyStimulus(8'hDE, 0);
      applyStimulus(8'hAD, 0);
      idleCycles(3);
      checkOutput("single_word_write", 32'(codeWrites), 32'(cw + 1));
      checkOutput("stay_halted", 32'(cpuRun), 32'd0);
      checkOutput("single_word_busy", 32'(busy), 32'd0);

      // Bad data address sets err without disturbing cpu_run; HALT clears it.
      applyStimulus(8'h80, 0);
      cw = codeWrites;
      dw = dataWrites;
      applyStimulus(8'h70, 0);
      idleCycles(2);
      checkOutput("bad_addr_err", 32'(err), 32'd1);
      checkOutput("bad_addr_idle", 32'(busy), 32'd0);
      checkOutput("bad_addr_run", 32'(cpuRun), 32'd1);
      checkOutput("bad_addr_nowrite", 32'(codeWrites + dataWrites), 32'(cw + dw));
      applyStimulus(8'hC0, 0);
      checkOutput("halt_err_clear", 32'(err), 32'd0);
      checkOutput("halt_run_clear", 32'(cpuRun), 32'd0);

      // Maximum length: 256 data bytes from address 0.
      dw = dataWrites;
      for (int i = 0; i < 256; i++)
         expectWrite(1'b0, 6'(i % 16), 16'(i[7:0] ^ 8'h5A));
      applyStimulus(8'h40, 0);
      readyLowCount = 0;
      applyStimulus(8'hFF, 0);
      for (int i = 0; i < 256; i++)
         applyStimulus(8'(i) ^ 8'h5A, 0);
      idleCycles(3);
      checkOutput("max_writes", 32'(dataWrites - dw), 32'd256);
      checkOutput("max_ready_low", 32'(readyLowCount), 32'd256);
      checkOutput("max_final_addr", 32'(dataAddr), 32'd15);
      checkOutput("max_busy", 32'(busy), 32'd0);

      // Reset in the middle of a code load, with the low byte already offered.
      applyStimulus(8'h70, 0);
      checkOutput("pre_reset_err", 32'(err), 32'd1);
      cw = codeWrites;
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h12, 0);
      inValid = 1'b1;
      inData  = 8'h34;
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midload_busy_in_reset", 32'(busy), 32'd0);
      idleCycles(2);
      inValid = 1'b0;
      reset   = 1'b1;
      idleCycles(4);
      checkOutput("midload_no_strobe", 32'(codeWrites), 32'(cw));
      checkOutput("midload_cpu_run", 32'(cpuRun), 32'd0);
      checkOutput("midload_busy", 32'(busy), 32'd0);
      checkOutput("midload_err", 32'(err), 32'd0);
      checkOutput("midload_ready", 32'(inReady), 32'd1);

      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
